// File: rtl/ps2_pkg.sv
// Shared constants and state encodings for the PS/2 key sequencer.
// Prefix states track F0/E0 framing; session states track text entry.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_NONE  = 8'h00;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    BREAK  = 2'd1,
    EXT    = 2'd2
  } prefix_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } session_e;

endpackage

// File: rtl/ps2_key_sequencer_char_fifo.sv
// First-word fall-through character FIFO, DEPTH x 7, with synchronous flush.
// Push at full is accepted only when a pop frees the head slot in the same cycle.
module char_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [6:0]               push_data_i,
  input  logic                     pop_i,
  output logic [6:0]               pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   count_next_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0]   FULL_CNT = CW'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = CW'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [6:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push_s;
  logic          do_pop_s;

  // Accept/advance decisions and next pointer/count values.
  always_comb begin
    do_pop_s  = pop_i && (count_q != {CW{1'b0}});
    do_push_s = push_i && ((count_q != FULL_CNT) || do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush_i) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + ONE_PTR;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + ONE_PTR;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + ONE_CNT;
        2'b01:   count_d = count_q - ONE_CNT;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush_i && !reset) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign empty_o      = (count_q == {CW{1'b0}});
  assign full_o       = (count_q == FULL_CNT);
  assign pop_data_o   = empty_o ? 7'h00 : mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/ps2_key_sequencer.sv
// Strips PS/2 break/extended prefixes and typematic repeats, runs a start/end
// text-entry session and buffers translated characters for a valid/ready consumer.
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int FILTER_REPEAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] scan_code,
  input  logic       key_start,
  input  logic       key_end,
  input  logic       key_valid,
  input  logic [6:0] ascii,
  output logic       rx_en,
  output logic [6:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       session_active,
  output logic       session_done,
  output logic       overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  prefix_e     prefix_q, prefix_d;
  session_e    session_q, session_d;
  logic [7:0]  last_key_q, last_key_d;
  logic        rx_en_q, rx_en_d;
  logic        done_q, done_d;
  logic        overflow_q, overflow_d;

  logic          accept_s;
  logic          push_s;
  logic          flush_s;
  logic          pop_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic [CW-1:0] fifo_count_next_s;

  assign pop_s = !fifo_empty_s && char_ready;

  // Prefix framing and repeat filter; flags a make code for session handling.
  always_comb begin
    prefix_d   = prefix_q;
    last_key_d = last_key_q;
    accept_s   = 1'b0;
    if (rx_done_tick) begin
      case (prefix_q)
        NORMAL: begin
          if (scan_code == SC_BREAK) begin
            prefix_d = BREAK;
          end else if (scan_code == SC_EXT) begin
            prefix_d = EXT;
          end else if ((FILTER_REPEAT != 0) && (scan_code == last_key_q)) begin
            prefix_d = NORMAL;
          end else begin
            last_key_d = scan_code;
            accept_s   = 1'b1;
          end
        end
        BREAK: begin
          if (scan_code == last_key_q) begin
            last_key_d = SC_NONE;
          end else begin
            last_key_d = last_key_q;
          end
          prefix_d = NORMAL;
        end
        EXT: begin
          // Extended make codes are dropped; only an extended break keeps framing.
          if (scan_code == SC_BREAK) begin
            prefix_d = BREAK;
          end else begin
            prefix_d = NORMAL;
          end
        end
        default: prefix_d = NORMAL;
      endcase
    end else begin
      prefix_d = prefix_q;
    end
  end

  // Session control: open/close, character push and overflow tracking.
  always_comb begin
    session_d  = session_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    push_s     = 1'b0;
    flush_s    = 1'b0;
    if (accept_s) begin
      case (session_q)
        IDLE: begin
          if (key_start) begin
            session_d  = ACTIVE;
            flush_s    = 1'b1;
            overflow_d = 1'b0;
          end else begin
            session_d = IDLE;
          end
        end
        ACTIVE: begin
          if (key_end) begin
            session_d = IDLE;
            done_d    = 1'b1;
          end else if (key_start) begin
            session_d = ACTIVE;
          end else if (key_valid) begin
            push_s = 1'b1;
            if (fifo_full_s && !pop_s) begin
              overflow_d = 1'b1;
            end else begin
              overflow_d = overflow_q;
            end
          end else begin
            session_d = ACTIVE;
          end
        end
        default: session_d = IDLE;
      endcase
    end else begin
      session_d = session_q;
    end
    rx_en_d = (fifo_count_next_s != FULL_CNT);
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      prefix_q   <= NORMAL;
      session_q  <= IDLE;
      last_key_q <= SC_NONE;
      rx_en_q    <= 1'b1;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      prefix_q   <= prefix_d;
      session_q  <= session_d;
      last_key_q <= last_key_d;
      rx_en_q    <= rx_en_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  char_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush_s),
    .push_i       (push_s),
    .push_data_i  (ascii),
    .pop_i        (pop_s),
    .pop_data_o   (char_data),
    .full_o       (fifo_full_s),
    .empty_o      (fifo_empty_s),
    .count_o      (fifo_count_s),
    .count_next_o (fifo_count_next_s)
  );

  assign rx_en          = rx_en_q;
  assign char_valid     = !fifo_empty_s;
  assign session_active = (session_q == ACTIVE);
  assign session_done   = done_q;
  assign overflow       = overflow_q;

  // Occupancy is observed through full/empty and the next-count; the live count is informational.
  logic unused_count_s;
  assign unused_count_s = ^fifo_count_s;

endmodule
